// File: rtl/datapath_generate_if.sv
// Bundle between the road-game control FSM / VGA adapter and the datapath.
// master: FSM side (drives phase enables and player lane, receives pixels and status).
// slave : datapath side.
//   erase_enable, draw_player_enable, draw_enable, draw_enable2, wait_enable : phase enables
//   player_lane : player lane select (3 clamps to 2)
//   lane_enable : lanes occupied by NPC cars
//   collide_yes : sticky collision flag
//   x, y, colour, plot : VGA pixel write
interface datapath_generate_if;
    logic       erase_enable;
    logic       draw_player_enable;
    logic       draw_enable;
    logic       draw_enable2;
    logic       wait_enable;
    logic [1:0] player_lane;
    logic [2:0] lane_enable;
    logic       collide_yes;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       plot;

    modport master (
        output erase_enable, draw_player_enable, draw_enable, draw_enable2, wait_enable, player_lane,
        input  lane_enable, collide_yes, x, y, colour, plot
    );

    modport slave (
        input  erase_enable, draw_player_enable, draw_enable, draw_enable2, wait_enable, player_lane,
        output lane_enable, collide_yes, x, y, colour, plot
    );
endinterface

// File: rtl/datapath_generate.sv
// Road-game datapath: turns one-hot phase enables into VGA pixel writes
// (full-screen erase, player sprite, up to two NPC cars), owns the NPC row,
// LFSR lane selection and collision detection.
// Ports:
//   clk    : system clock
//   resetn : synchronous reset, active low
//   bus    : datapath_generate_if.slave (enables in; lane_enable, collide_yes, x/y/colour/plot out)
// Optional feature: define DATAPATH_SPEED_RAMP_EN to make the NPC step grow by one
// on every car wrap, saturating at 4; otherwise the step is fixed.
module datapath_generate (
    input  logic                 clk,
    input  logic                 resetn,
    datapath_generate_if.slave   bus
);
    localparam int unsigned SCREEN_W   = 160;
    localparam int unsigned SCREEN_H   = 120;
    localparam int unsigned SPRITE_W   = 21;
    localparam int unsigned SPRITE_H   = 30;
    localparam int unsigned LANE_X0    = 20;
    localparam int unsigned LANE_PITCH = 50;
    localparam int unsigned PLAYER_Y   = 88;
    localparam int unsigned CAR_STEP   = 2;
    localparam int unsigned STEP_MAX   = 4;

    localparam logic [2:0] PH_NONE   = 3'd0;
    localparam logic [2:0] PH_ERASE  = 3'd1;
    localparam logic [2:0] PH_PLAYER = 3'd2;
    localparam logic [2:0] PH_DRAW   = 3'd3;
    localparam logic [2:0] PH_DRAW2  = 3'd4;

    logic [2:0] phase_q, phase_c;
    logic       first_c;
    logic [7:0] sx_q, sx_c, sx_next;
    logic [6:0] sy_q, sy_c, sy_next;
    logic [7:0] w_last_c;
    logic [6:0] h_last_c;
    logic [1:0] pl_in_c, plane_q, plane_next;
    logic [1:0] first_lane_c, second_lane_c;
    logic       second_ok_c;
    logic [7:0] car_row_c;
    logic       clip_c;
    logic [6:0] car_y_q, car_y_next;
    logic [7:0] car_sum_c;
    logic       wrap_c;
    logic [2:0] lane_q, lane_next;
    logic [7:0] lfsr_q, lfsr_next;
    logic       wait_q;
    logic       hit_c;
    logic       collide_q, collide_next;
    logic [7:0] x_q, x_next;
    logic [6:0] y_q, y_next;
    logic [2:0] colour_q, colour_next;
    logic       plot_q, plot_next;
    logic [2:0] step_c;

    function automatic logic [7:0] lane_x(input logic [1:0] lane);
        return 8'(LANE_X0) + 8'(LANE_PITCH) * {6'd0, lane};
    endfunction

    // Phase decode with erase > player > draw > draw2 priority.
    always_comb begin
        phase_c = PH_NONE;
        if (bus.erase_enable)            phase_c = PH_ERASE;
        else if (bus.draw_player_enable) phase_c = PH_PLAYER;
        else if (bus.draw_enable)        phase_c = PH_DRAW;
        else if (bus.draw_enable2)       phase_c = PH_DRAW2;
    end

    // A phase change (including from idle) restarts the pixel walk at 0.
    always_comb begin
        first_c  = (phase_c != phase_q);
        sx_c     = first_c ? 8'd0 : sx_q;
        sy_c     = first_c ? 7'd0 : sy_q;
        w_last_c = (phase_c == PH_ERASE) ? 8'(SCREEN_W - 1) : 8'(SPRITE_W - 1);
        h_last_c = (phase_c == PH_ERASE) ? 7'(SCREEN_H - 1) : 7'(SPRITE_H - 1);
        sx_next  = sx_c;
        sy_next  = sy_c;
        if (phase_c == PH_NONE) begin
            sx_next = 8'd0;
            sy_next = 7'd0;
        end else if (sx_c == w_last_c) begin
            if (sy_c != h_last_c) begin
                sx_next = 8'd0;
                sy_next = sy_c + 7'd1;
            end
        end else begin
            sx_next = sx_c + 8'd1;
        end
    end

    // Lane targets: lowest set bit for DRAW, next set bit for DRAW2.
    always_comb begin
        first_lane_c  = 2'd2;
        second_lane_c = 2'd2;
        second_ok_c   = 1'b0;
        if (lane_q[0]) begin
            first_lane_c = 2'd0;
            if (lane_q[1]) begin
                second_lane_c = 2'd1;
                second_ok_c   = 1'b1;
            end else begin
                second_ok_c   = lane_q[2];
            end
        end else if (lane_q[1]) begin
            first_lane_c = 2'd1;
            second_ok_c  = lane_q[2];
        end
    end

`ifdef DATAPATH_SPEED_RAMP_EN
    logic [2:0] step_q;
    assign step_c = step_q;

    always_ff @(posedge clk) begin
        if (!resetn)                                  step_q <= 3'(CAR_STEP);
        else if (wrap_c && step_q < 3'(STEP_MAX))     step_q <= step_q + 3'd1;
    end
`else
    assign step_c = 3'(CAR_STEP);
`endif

    // Pixel generation, car motion, lane reload and collision.
    always_comb begin
        pl_in_c    = (bus.player_lane == 2'd3) ? 2'd2 : bus.player_lane;
        plane_next = (phase_c == PH_PLAYER && first_c) ? pl_in_c : plane_q;
        car_row_c  = {1'b0, car_y_q} + {1'b0, sy_c};
        clip_c     = (car_row_c >= 8'(SCREEN_H));

        x_next      = x_q;
        y_next      = y_q;
        colour_next = colour_q;
        plot_next   = 1'b0;
        case (phase_c)
            PH_ERASE: begin
                x_next      = sx_c;
                y_next      = sy_c;
                colour_next = 3'b000;
                plot_next   = 1'b1;
            end
            PH_PLAYER: begin
                x_next      = lane_x(plane_next) + sx_c;
                y_next      = 7'(PLAYER_Y) + sy_c;
                colour_next = 3'b010;
                plot_next   = 1'b1;
            end
            PH_DRAW: begin
                x_next      = lane_x(first_lane_c) + sx_c;
                y_next      = car_row_c[6:0];
                colour_next = 3'b100;
                plot_next   = !clip_c;
            end
            PH_DRAW2: begin
                x_next      = lane_x(second_lane_c) + sx_c;
                y_next      = car_row_c[6:0];
                colour_next = 3'b100;
                plot_next   = second_ok_c && !clip_c;
            end
            default: plot_next = 1'b0;
        endcase

        car_sum_c  = {1'b0, car_y_q} + {5'd0, step_c};
        wrap_c     = bus.wait_enable && !wait_q && (car_sum_c >= 8'(SCREEN_H));
        car_y_next = car_y_q;
        lane_next  = lane_q;
        if (wrap_c) begin
            car_y_next = 7'd0;
            case (lfsr_q[2:0])
                3'b000:  lane_next = 3'b001;
                3'b111:  lane_next = 3'b101;
                default: lane_next = lfsr_q[2:0];
            endcase
        end else if (bus.wait_enable && !wait_q) begin
            car_y_next = car_sum_c[6:0];
        end

        // Taps x^8+x^6+x^5+x^4+1.
        lfsr_next = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

        hit_c = lane_q[pl_in_c]
             && ({1'b0, car_y_q} < 8'(PLAYER_Y + SPRITE_H))
             && (({1'b0, car_y_q} + 8'(SPRITE_H)) > 8'(PLAYER_Y));
        collide_next = collide_q | (phase_c == PH_DRAW && first_c && hit_c);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            phase_q   <= PH_NONE;
            sx_q      <= 8'd0;
            sy_q      <= 7'd0;
            plane_q   <= 2'd0;
            car_y_q   <= 7'd0;
            lane_q    <= 3'b010;
            lfsr_q    <= 8'hA5;
            wait_q    <= 1'b0;
            collide_q <= 1'b0;
            x_q       <= 8'd0;
            y_q       <= 7'd0;
            colour_q  <= 3'b000;
            plot_q    <= 1'b0;
        end else begin
            phase_q   <= phase_c;
            sx_q      <= sx_next;
            sy_q      <= sy_next;
            plane_q   <= plane_next;
            car_y_q   <= car_y_next;
            lane_q    <= lane_next;
            lfsr_q    <= lfsr_next;
            wait_q    <= bus.wait_enable;
            collide_q <= collide_next;
            x_q       <= x_next;
            y_q       <= y_next;
            colour_q  <= colour_next;
            plot_q    <= plot_next;
        end
    end

    assign bus.lane_enable = lane_q;
    assign bus.collide_yes = collide_q;
    assign bus.x           = x_q;
    assign bus.y           = y_q;
    assign bus.colour      = colour_q;
    assign bus.plot        = plot_q;
endmodule
